// File: rtl/countdown_timer.sv
// countdown_timer: phase countdown generator. Loads a duration in seconds,
// decrements it once every TICK_DIV clocks of running time, and pulses
// tick/done for the display decoder and traffic-light controller.
module countdown_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       pause,
  input  logic       en,
  output logic [4:0] count,
  output logic       disp_en,
  output logic       tick,
  output logic       done,
  output logic       busy
);

  // Prescaler must be able to hold TICK_DIV-1; keep at least one bit.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // A divider below 2 would make the prescaler meaningless.
  if (TICK_DIV < 2) begin : g_bad_div
    $error("countdown_timer: TICK_DIV must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [4:0]      count_q, count_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            disp_en_q;

  // Running time is consumed on every cycle the countdown is active and
  // pause is low. Leaving PAUSED counts that same cycle as running time,
  // so a pause of P cycles delays every later decrement by exactly P.
  logic run_cycle;
  assign run_cycle = (state_q == RUN || state_q == PAUSED) && !pause;

  // Next-state, prescaler, count and pulse computation; load has top priority.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (load) begin
      // Restart discards any coincident wrap, tick or done.
      presc_d = '0;
      count_d = load_val;
      if (load_val != 5'd0) begin
        state_d = pause ? PAUSED : RUN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
        end
        RUN, PAUSED: begin
          if (!run_cycle) begin
            // Pause wins over a coincident wrap: everything freezes.
            state_d = PAUSED;
          end else begin
            state_d = RUN;
            if (presc_q == PRESC_MAX) begin
              presc_d = '0;
              // count is always >= 1 while active; guard anyway so it
              // can never wrap below zero.
              if (count_q != 5'd0) begin
                count_d = count_q - 5'd1;
                tick_d  = 1'b1;
              end
              if (count_q <= 5'd1) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= 5'd0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Display enable is a plain one-cycle delay of en, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_en_q <= 1'b0;
    end else begin
      disp_en_q <= en;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign disp_en = disp_en_q;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Phase countdown generator that drives the 5-bit `count` / `en` pair consumed by the display decoder path. It loads a phase duration in seconds, decrements it once per prescaled tick, and signals expiry to the traffic-light controller. It supports pause/resume and reload at any time.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per count decrement (1 s at 50 MHz); legal range ≥ 2; prescaler width = clog2(TICK_DIV).
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `load`  input  1  single-cycle strobe that loads `load_val` and starts the countdown.
- `load_val`  input  5  duration in seconds, 0–31.
- `pause`  input  1  level; freezes the countdown while high.
- `en`  input  1  display enable request, level.
- `count`  output  5  current remaining seconds; feeds the decoder `count`.
- `disp_en`  output  1  registered copy of `en`; feeds the decoder `en`.
- `tick`  output  1  one-cycle pulse on each decrement.
- `done`  output  1  one-cycle pulse when `count` reaches 0.
- `busy`  output  1  high while a countdown is in progress (RUN or PAUSED).

## Operation
- FSM states: IDLE, RUN, PAUSED. All outputs are registered.
- Reset values: state=IDLE, prescaler=0, count=0, tick=0, done=0, busy=0, disp_en=0.
- **IDLE:** count holds its value and the prescaler holds at 0.
- **`load` from IDLE:**
  - `load_val`≠0: count←`load_val`, prescaler←0, go to RUN (or PAUSED if `pause` is high in the same cycle).
  - `load_val`=0: count←0, done←1, stay in IDLE.
- **RUN:** the prescaler increments each cycle. When prescaler = TICK_DIV−1:
  - prescaler←0, count←count−1, tick←1.
  - If count was 1: done←1 and go to IDLE.
- **`pause` high in RUN:** go to PAUSED. The prescaler and count freeze with their values kept.
- **`pause` low in PAUSED:** go to RUN. The prescaler resumes from its frozen value, so no time is lost or gained.
- **Priority, highest first:** `load` > `pause` > prescaler wrap.
  - `load` in any state restarts the countdown per the `load` rules above and discards any coincident tick or done.
  - A wrap and `pause` rising in the same cycle: the pause wins and no decrement occurs.
- `count` never underflows. Decrement happens only in RUN with count ≥ 1, and count=0 always means IDLE.
- `disp_en` ← `en` every cycle, in every state, independent of the FSM.
- `busy` = 1 exactly when state ∈ {RUN, PAUSED}.

## Timing
- **Load latency:** `load` sampled at edge k → count=`load_val` and busy=1 after edge k.
- **Decrement spacing:** the first decrement lands at edge k+TICK_DIV, with no pause. Each later decrement follows every TICK_DIV cycles of RUN time.
- **Total duration:** load of N (N≥1) → count=0, done=1, busy=0 after edge k+N·TICK_DIV, plus the number of cycles spent in PAUSED.
- **Pulse alignment:**
  - `tick` is high for exactly one cycle, aligned with the new count value.
  - `done` is high for exactly one cycle, aligned with count=0, and coincides with the final `tick`.
- **`done` on zero load:** a load of 0 gives done=1 one cycle after the load edge, with no tick.
- **Reload mid-count:** the new value appears the next cycle, the prescaler is cleared, and no done pulse is produced for the aborted countdown.
- **`disp_en`:** follows `en` with 1 cycle latency.
- **Async reset:** asserting `rst_n` at any point forces the reset values immediately. The first `load` is accepted on the first edge after release.

## Test plan
- **Reset:** with TICK_DIV=4, hold rst_n low mid-count (count=7) → all outputs 0 immediately. After release, the block stays in IDLE with count=0 until a load.
- **Basic countdown:** load 3 at edge k → count 3,2,1,0 at k, k+4, k+8, k+12. Three tick pulses. done=1 and busy=0 only at k+12.
- **Pause:** load 5, raise pause for 10 cycles mid-prescale → every later decrement is delayed by exactly 10 cycles, and count never changes while paused.
- **Reload and zero load:**
  - Load 2; at count=1, load 31 → count=31 the next cycle, prescaler restarted, no done pulse.
  - Load 0 → done pulse one cycle later, busy stays 0, no tick.
- **Priority collisions:**
  - `load` coincident with the final wrap → count=`load_val`, no done.
  - `pause` coincident with a wrap → no decrement.
- **Display enable:** toggle `en` randomly during a 31-second countdown → `disp_en` equals `en` delayed 1 cycle, and count/tick/done are unaffected.
